// File: rtl/rv_core_pkg.sv
// rtl/rv_core_pkg.sv - shared types and constants for the PC redirect logic
package rv_core_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } redir_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          FLUSH_CNT_W      = 3;

endpackage

// File: rtl/redirect_target_sel.sv
// rtl/redirect_target_sel.sv - redirect target mux with JALR LSB clear and alignment check
module redirect_target_sel
    import rv_core_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  pc_s_a_1,
    input  logic [DATA_WIDTH-1:0] jalr_target,
    input  logic [DATA_WIDTH-1:0] branch_target,
    output logic [DATA_WIDTH-1:0] target,
    output logic                  misaligned
);

    // JALR clears bit 0 of rs1+imm; branch targets pass through untouched.
    // Only bit 1 is checked: bit 0 is either cleared (JALR) or always zero for branches.
    always_comb begin
        target     = pc_s_a_1 ? {jalr_target[DATA_WIDTH-1:1], 1'b0} : branch_target;
        misaligned = target[1];
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - EX-stage PC register, redirect acceptance and wrong-path flush
module pc_redirect_ctrl
    import rv_core_pkg::*;
#(
    parameter int                     DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0]  RESET_PC     = RESET_PC_DEFAULT,
    parameter int                     FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic                  hold_pipeline,
    input  logic                  pc_s_a_1,
    input  logic                  branch_taken,
    input  logic [DATA_WIDTH-1:0] jalr_target,
    input  logic [DATA_WIDTH-1:0] branch_target,
    input  logic                  fetch_ready,
    output logic [DATA_WIDTH-1:0] pc,
    output logic                  flush,
    output logic                  stall_fetch,
    output logic                  misalign_fault,
    output logic [15:0]           redirect_count
);

    localparam logic [FLUSH_CNT_W-1:0] FCNT_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    redir_state_t            state, state_next;
    logic [FLUSH_CNT_W-1:0]  fcnt, fcnt_next;
    logic [DATA_WIDTH-1:0]   pc_next;
    logic [DATA_WIDTH-1:0]   target;
    logic                    target_misaligned;
    logic                    req;
    logic                    accept;
    logic                    fault_next;
    logic                    count_inc;

    redirect_target_sel #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_target_sel (
        .pc_s_a_1      (pc_s_a_1),
        .jalr_target   (jalr_target),
        .branch_target (branch_target),
        .target        (target),
        .misaligned    (target_misaligned)
    );

    // Next-state, next-PC and flush/stall outputs; redirect beats the sequential advance.
    always_comb begin
        state_next  = state;
        fcnt_next   = fcnt;
        pc_next     = pc;
        accept      = 1'b0;
        fault_next  = 1'b0;
        flush       = 1'b0;
        stall_fetch = 1'b0;
        req         = ex_valid & hold_pipeline & (state == IDLE);

        case (state)
            IDLE: begin
                stall_fetch = ~fetch_ready;
                if (req && !target_misaligned) begin
                    accept     = 1'b1;
                    pc_next    = target;
                    fcnt_next  = FCNT_LOAD;
                    state_next = FLUSH;
                end else begin
                    fault_next = req;
                    if (fetch_ready) begin
                        pc_next = pc + DATA_WIDTH'(4);
                    end
                end
            end
            FLUSH: begin
                flush       = 1'b1;
                stall_fetch = 1'b1;
                if (fcnt == '0) begin
                    state_next = IDLE;
                end else begin
                    fcnt_next = fcnt - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // JALR redirects always count; branch redirects count only when the ALU resolved them taken.
        count_inc = accept & (pc_s_a_1 | branch_taken);
    end

    // State, PC, fault pulse and saturating redirect counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            fcnt           <= '0;
            pc             <= RESET_PC;
            misalign_fault <= 1'b0;
            redirect_count <= '0;
        end else begin
            state          <= state_next;
            fcnt           <= fcnt_next;
            pc             <= pc_next;
            misalign_fault <= fault_next;
            if (count_inc && (redirect_count != 16'hFFFF)) begin
                redirect_count <= redirect_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - directed self-checking bench for pc_redirect_ctrl
module tb_pc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        hold_pipeline;
    logic        pc_s_a_1;
    logic        branch_taken;
    logic [31:0] jalr_target;
    logic [31:0] branch_target;
    logic        fetch_ready;
    logic [31:0] pc;
    logic        flush;
    logic        stall_fetch;
    logic        misalign_fault;
    logic [15:0] redirect_count;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    pc_redirect_ctrl #(
        .DATA_WIDTH   (32),
        .RESET_PC     (32'h0000_0000),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .hold_pipeline  (hold_pipeline),
        .pc_s_a_1       (pc_s_a_1),
        .branch_taken   (branch_taken),
        .jalr_target    (jalr_target),
        .branch_target  (branch_target),
        .fetch_ready    (fetch_ready),
        .pc             (pc),
        .flush          (flush),
        .stall_fetch    (stall_fetch),
        .misalign_fault (misalign_fault),
        .redirect_count (redirect_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic no_req();
        ex_valid      = 1'b0;
        hold_pipeline = 1'b0;
        branch_taken  = 1'b0;
        pc_s_a_1      = 1'b0;
    endtask

    task automatic branch_req(input logic [31:0] tgt);
        ex_valid      = 1'b1;
        hold_pipeline = 1'b1;
        branch_taken  = 1'b1;
        pc_s_a_1      = 1'b0;
        branch_target = tgt;
    endtask

    task automatic jalr_req(input logic [31:0] tgt);
        ex_valid      = 1'b1;
        hold_pipeline = 1'b1;
        branch_taken  = 1'b0;
        pc_s_a_1      = 1'b1;
        jalr_target   = tgt;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_ready = 1'b1; jalr_target = '0; branch_target = '0;
        no_req();
        step(); step();
        total++; if (pc !== 32'h0) $display("FAIL reset_pc got %h want %h", pc, 32'h0); else pass_cnt++;
        total++; if (flush !== 1'b0) $display("FAIL reset_flush got %b want 0", flush); else pass_cnt++;
        total++; if (redirect_count !== 16'd0) $display("FAIL reset_count got %0d want 0", redirect_count); else pass_cnt++;
        total++; if (misalign_fault !== 1'b0) $display("FAIL reset_fault got %b want 0", misalign_fault); else pass_cnt++;
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            total++; if (pc !== 32'(4 * i)) $display("FAIL fetch_seq_%0d got %h want %h", i, pc, 32'(4 * i)); else pass_cnt++;
            total++; if (flush !== 1'b0) $display("FAIL fetch_flush_%0d got %b want 0", i, flush); else pass_cnt++;
        end
        for (int i = 0; i < 13; i++) step();
        total++; if (pc !== 32'h40) $display("FAIL fetch_to_40 got %h want %h", pc, 32'h40); else pass_cnt++;
    endtask

    task automatic test_forward_branch();
        branch_req(32'h100); fetch_ready = 1'b1;
        step();
        total++; if (pc !== 32'h100) $display("FAIL br_pc got %h want %h", pc, 32'h100); else pass_cnt++;
        total++; if (flush !== 1'b1) $display("FAIL br_flush1 got %b want 1", flush); else pass_cnt++;
        total++; if (stall_fetch !== 1'b1) $display("FAIL br_stall1 got %b want 1", stall_fetch); else pass_cnt++;
        total++; if (redirect_count !== 16'd1) $display("FAIL br_count got %0d want 1", redirect_count); else pass_cnt++;
        branch_req(32'h300);
        step();
        total++; if (pc !== 32'h100) $display("FAIL flush_ignore_pc got %h want %h", pc, 32'h100); else pass_cnt++;
        total++; if (flush !== 1'b1) $display("FAIL br_flush2 got %b want 1", flush); else pass_cnt++;
        total++; if (redirect_count !== 16'd1) $display("FAIL flush_ignore_count got %0d want 1", redirect_count); else pass_cnt++;
        no_req();
        step();
        total++; if (flush !== 1'b0) $display("FAIL br_flush3 got %b want 0", flush); else pass_cnt++;
        total++; if (pc !== 32'h100) $display("FAIL br_pc_hold got %h want %h", pc, 32'h100); else pass_cnt++;
        step();
        total++; if (pc !== 32'h104) $display("FAIL br_pc_next got %h want %h", pc, 32'h104); else pass_cnt++;
    endtask

    task automatic test_jalr();
        jalr_req(32'h201);
        step();
        total++; if (pc !== 32'h200) $display("FAIL jalr_pc got %h want %h", pc, 32'h200); else pass_cnt++;
        total++; if (redirect_count !== 16'd2) $display("FAIL jalr_count got %0d want 2", redirect_count); else pass_cnt++;
        no_req();
        step(); step();
        total++; if (flush !== 1'b0) $display("FAIL jalr_flush_end got %b want 0", flush); else pass_cnt++;
        step();
        total++; if (pc !== 32'h204) $display("FAIL jalr_pc_next got %h want %h", pc, 32'h204); else pass_cnt++;
        jalr_req(32'h202);
        step();
        total++; if (misalign_fault !== 1'b1) $display("FAIL mis_pulse got %b want 1", misalign_fault); else pass_cnt++;
        total++; if (flush !== 1'b0) $display("FAIL mis_flush got %b want 0", flush); else pass_cnt++;
        total++; if (pc !== 32'h208) $display("FAIL mis_pc got %h want %h", pc, 32'h208); else pass_cnt++;
        total++; if (redirect_count !== 16'd2) $display("FAIL mis_count got %0d want 2", redirect_count); else pass_cnt++;
        no_req();
        step();
        total++; if (misalign_fault !== 1'b0) $display("FAIL mis_pulse_end got %b want 0", misalign_fault); else pass_cnt++;
        total++; if (pc !== 32'h20C) $display("FAIL mis_pc_next got %h want %h", pc, 32'h20C); else pass_cnt++;
    endtask

    task automatic test_wrap_and_hold();
        branch_req(32'hFFFF_FFFC);
        step();
        total++; if (pc !== 32'hFFFF_FFFC) $display("FAIL wrap_tgt got %h want %h", pc, 32'hFFFF_FFFC); else pass_cnt++;
        total++; if (redirect_count !== 16'd3) $display("FAIL wrap_count got %0d want 3", redirect_count); else pass_cnt++;
        no_req();
        step(); step(); step();
        total++; if (pc !== 32'h0) $display("FAIL wrap_pc got %h want %h", pc, 32'h0); else pass_cnt++;
        fetch_ready = 1'b0;
        #1;
        total++; if (stall_fetch !== 1'b1) $display("FAIL idle_stall got %b want 1", stall_fetch); else pass_cnt++;
        step();
        total++; if (pc !== 32'h0) $display("FAIL hold_pc got %h want %h", pc, 32'h0); else pass_cnt++;
        fetch_ready = 1'b1;
        ex_valid = 1'b1; hold_pipeline = 1'b0; branch_taken = 1'b1; branch_target = 32'h800;
        step();
        total++; if (pc !== 32'h4) $display("FAIL backward_pc got %h want %h", pc, 32'h4); else pass_cnt++;
        total++; if (flush !== 1'b0) $display("FAIL backward_flush got %b want 0", flush); else pass_cnt++;
        total++; if (redirect_count !== 16'd3) $display("FAIL backward_count got %0d want 3", redirect_count); else pass_cnt++;
        no_req();
    endtask

    task automatic test_reset_mid_flush();
        branch_req(32'h500);
        step();
        no_req();
        step();
        total++; if (flush !== 1'b1) $display("FAIL midrst_flush_pre got %b want 1", flush); else pass_cnt++;
        rst = 1'b1;
        step();
        total++; if (pc !== 32'h0) $display("FAIL midrst_pc got %h want %h", pc, 32'h0); else pass_cnt++;
        total++; if (flush !== 1'b0) $display("FAIL midrst_flush got %b want 0", flush); else pass_cnt++;
        total++; if (redirect_count !== 16'd0) $display("FAIL midrst_count got %0d want 0", redirect_count); else pass_cnt++;
        rst = 1'b0;
        step();
        total++; if (flush !== 1'b0) $display("FAIL midrst_residual got %b want 0", flush); else pass_cnt++;
        total++; if (pc !== 32'h4) $display("FAIL midrst_pc_next got %h want %h", pc, 32'h4); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_forward_branch();
        test_jalr();
        test_wrap_and_hold();
        test_reset_mid_flush();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
